// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl: iterative AES key schedule, one word per cycle into a shadow bank,
// swapped into the active round-key bank only on an engine sync boundary.
module subbytes_block #(
    parameter int N_BYTES = 4
) (
    input  logic [N_BYTES*8-1:0] data,
    output logic [N_BYTES*8-1:0] result
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = b[k] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 7; k >= 0; k--) begin
            r = gmul(r, r);
            r = (k != 0) ? gmul(r, a) : r;
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        result = '0;
        for (int b = 0; b < N_BYTES; b++) result[b*8 +: 8] = sbox(data[b*8 +: 8]);
    end
endmodule

module key_expansion_ctrl #(
    parameter int NB_BYTE       = 8,
    parameter int N_BYTES_STATE = 16,
    parameter int N_BYTES_KEY   = 32,
    parameter int N_ROUNDS      = 14
) (
    input  logic                                          i_clock,
    input  logic                                          i_reset,
    input  logic [N_BYTES_KEY*NB_BYTE-1:0]                i_key,
    input  logic                                          i_key_valid,
    output logic                                          o_key_ready,
    input  logic                                          i_sync,
    output logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS+1)-1:0] o_round_key_vector,
    output logic                                          o_key_pending,
    output logic                                          o_key_update,
    output logic                                          o_busy
);
    localparam int WW  = 4 * NB_BYTE;
    localparam int NK  = N_BYTES_KEY / 4;
    localparam int NW  = 4 * (N_ROUNDS + 1);
    localparam int CW  = $clog2(NW + 1);
    localparam int RKW = N_BYTES_STATE * NB_BYTE * (N_ROUNDS + 1);

    if (NB_BYTE != 8 || N_BYTES_STATE != 16 || !(NK == 4 || NK == 6 || NK == 8) || N_ROUNDS != NK + 6) begin : g_bad_cfg
        $error("key_expansion_ctrl: unsupported configuration");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, WAIT_SYNC} state_t;

    state_t         state, next;
    logic [WW-1:0]  shadow [NW];
    logic [WW-1:0]  win [NK];
    logic [RKW-1:0] shadow_vec;
    logic [CW-1:0]  cnt;
    logic [2:0]     phase;
    logic [7:0]     rcon;
    logic [WW-1:0]  t, sub_in, sub_out, temp, w_new;

    // win[0] is w[i-NK], win[NK-1] is w[i-1]; phase tracks i mod NK
    assign t      = win[NK-1];
    assign sub_in = (phase == 3'd0) ? {t[WW-NB_BYTE-1:0], t[WW-1 -: NB_BYTE]} : t;
    assign temp   = (phase == 3'd0) ? sub_out ^ {rcon, 24'h0} : (NK > 6 && phase == 3'd4) ? sub_out : t;
    assign w_new  = win[0] ^ temp;

    subbytes_block #(.N_BYTES(4)) u_sbox (.data(sub_in), .result(sub_out));

    // round-major packing, first word of each round in the MSBs of its 128-bit slot
    always_comb begin
        shadow_vec = '0;
        for (int n = 0; n < NW; n++) shadow_vec[(n ^ 3)*WW +: WW] = shadow[n];
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= next;
    end

    always_comb begin
        next          = state;
        o_key_ready   = 1'b0;
        o_busy        = 1'b0;
        o_key_pending = 1'b0;
        case (state)
            IDLE: begin
                o_key_ready = 1'b1;
                next        = i_key_valid ? EXPAND : IDLE;
            end
            EXPAND: begin
                o_busy = 1'b1;
                next   = (cnt == CW'(NW - 1)) ? WAIT_SYNC : EXPAND;
            end
            WAIT_SYNC: begin
                o_key_pending = 1'b1;
                next          = i_sync ? IDLE : WAIT_SYNC;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int n = 0; n < NW; n++) shadow[n] <= '0;
            for (int n = 0; n < NK; n++) win[n] <= '0;
            o_round_key_vector <= '0;
            cnt                <= '0;
            phase              <= '0;
            rcon               <= 8'h01;
            o_key_update       <= 1'b0;
        end else begin
            o_key_update <= state == WAIT_SYNC && i_sync;
            if (state == IDLE && i_key_valid) begin
                for (int n = 0; n < NK; n++) begin
                    shadow[n] <= i_key[(NK-1-n)*WW +: WW];
                    win[n]    <= i_key[(NK-1-n)*WW +: WW];
                end
                cnt   <= CW'(NK);
                phase <= '0;
                rcon  <= 8'h01;
            end
            if (state == EXPAND) begin
                shadow[cnt] <= w_new;
                for (int n = 0; n < NK - 1; n++) win[n] <= win[n+1];
                win[NK-1] <= w_new;
                cnt       <= cnt + 1'b1;
                phase     <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
                rcon      <= (phase == 3'd0) ? {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00) : rcon;
            end
            if (state == WAIT_SYNC && i_sync) o_round_key_vector <= shadow_vec;
        end
    end
endmodule

// File: doc/key_expansion_ctrl.md
Name: key_expansion_ctrl

Overview:
Iterative AES key-expansion sequencer for the GCM/AES engine. It accepts a new cipher key over a valid/ready handshake and computes the round-key schedule one 32-bit word per cycle into a shadow bank, sharing a single 4-byte S-box instance across all words. It then swaps the shadow bank into the active round-key bank only at an engine sync boundary. This allows rekeying without disturbing traffic that is in flight.

Parameters:
NB_BYTE, 8, bits per byte; any other value is a bad configuration.
N_BYTES_STATE, 16, bytes per round key.
N_BYTES_KEY, 32, cipher key bytes (16/24/32); NK = N_BYTES_KEY/4.
N_ROUNDS, 14, AES rounds (10/12/14, must match NK = 4/6/8).

Ports:
i_clock  in  1  clock.
i_reset  in  1  asynchronous, active-high reset.
i_key  in  N_BYTES_KEY*NB_BYTE  new cipher key; word 0 in the MSBs.
i_key_valid  in  1  key offered.
o_key_ready  out  1  block can accept a key (state IDLE).
i_sync  in  1  engine boundary; the bank swap is allowed in this cycle.
o_round_key_vector  out  N_BYTES_STATE*NB_BYTE*(N_ROUNDS+1)  active bank; round r at [r*128 +: 128], first word of each round in the MSBs.
o_key_pending  out  1  shadow bank complete, waiting for i_sync.
o_key_update  out  1  one-cycle pulse; the active bank changed this cycle.
o_busy  out  1  expansion in progress.

Behaviour:
- NW = 4*(N_ROUNDS+1) total words; NE = NW-NK expansion cycles (52 for AES-256, 40 for AES-128).
- Reset (async assert, sync deassert):
  - State goes to IDLE; active and shadow banks clear to 0.
  - o_key_ready=1 after reset; o_key_pending=0, o_key_update=0, o_busy=0.
  - Word counter clears to 0; Rcon register resets to 0x01.
- FSM IDLE:
  - o_key_ready=1.
  - On i_key_valid & o_key_ready: write w[0..NK-1] into shadow and an NK-word sliding window; counter=NK; Rcon=0x01; go to EXPAND.
- FSM EXPAND (o_busy=1, o_key_ready=0):
  - Each cycle computes w[i] = w[i-NK] ^ temp, where t = w[i-1].
  - If i%NK==0: temp = SubWord(RotWord(t)) ^ {Rcon,24'h0}, and Rcon <= xtime(Rcon) (0x80 -> 0x1b).
  - Else if NK>6 and i%NK==4: temp = SubWord(t).
  - Otherwise temp = t.
  - w[i] is written to the shadow bank and shifted into the window; counter increments.
  - One S-box instance (subbytes_block, N_BYTES=4, no output register) is fed by a mux.
  - When i==NW-1 the word is written and the FSM goes to WAIT_SYNC.
- FSM WAIT_SYNC:
  - o_key_pending=1; o_key_ready=0, so any new key stalls.
  - On the first cycle with i_sync=1: active bank <= shadow (registered); o_key_update pulses in the cycle the new value appears; go to IDLE.
- Latency, with handshake at cycle 0:
  - Last word is written at the end of cycle NE.
  - o_key_pending=1 from cycle NE+1.
  - With i_sync held high, the swap registers at the end of cycle NE+1; the new o_round_key_vector and the o_key_update pulse appear in cycle NE+2 (54 for AES-256).
- i_sync outside WAIT_SYNC is ignored. The active bank is never partially updated and is stable at all other times.
- i_key_valid held while not ready: the key is not consumed; the source must hold i_key stable until the handshake.
- Reset mid-EXPAND or mid-WAIT_SYNC: the operation is aborted and both banks are cleared. No o_key_update pulse is generated.
- Back-to-back keys: the next key can be accepted the cycle after the swap (IDLE).

Test Plan:
- AES-256 FIPS-197 A.3 key 603deb10…0914dff4, i_sync=1 → o_key_update in cycle 54; round 14 = fe4890d1e6188d0b046df344706c631e; round 0 = key[255:128].
- AES-128 build (N_BYTES_KEY=16, N_ROUNDS=10), key 2b7e151628aed2a6abf7158809cf4f3c → round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; checks Rcon wrap to 0x1b/0x36; o_key_update in cycle 42.
- i_sync held low for 100 cycles after done → o_key_pending=1 and active bank still holding the old keys; pulse i_sync → swap next cycle; o_key_pending drops.
- Second key presented during EXPAND/WAIT_SYNC → o_key_ready=0 and no capture; accepted the cycle after the swap; final bank matches the second key's schedule.
- Assert i_reset at expansion cycle 20 → all outputs 0 and o_key_ready=1 immediately; no o_key_update; a fresh key afterwards expands correctly.
- Key 0x00…00 (AES-256) → round 14 matches the reference model; an i_sync pulse in IDLE produces no o_key_update.
